ws2812b_tx: RTL and testbench
=============================

# ws2812b_tx

Serializer for WS2812B LED chains, sitting directly downstream of the slot-tick generator `clk_gen`. It accepts 24-bit GRB pixels over a valid/ready handshake and drives the single-wire `dout` line. Each bit is built from a fixed number of tick-timed slots: a 0-bit is a short high pulse and a 1-bit is a long high pulse. After the pixel flagged as last, it drives a low latch (reset) gap and then reports frame completion.

## Interface
Parameters:
- `BITS_PER_PIXEL`, 24: bits shifted out per pixel, MSB first.
- `SLOTS_PER_BIT`, 3: tick slots per bit period.
- `T0H_SLOTS`, 1: high slots for a 0-bit (< `T1H_SLOTS`).
- `T1H_SLOTS`, 2: high slots for a 1-bit (< `SLOTS_PER_BIT`).
- `RESET_SLOTS`, 128: low slots in the latch gap (≥50 µs at the chosen tick rate).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle slot strobe, connected to `clk_gen.clk_out`.
- `pixel_data` in `BITS_PER_PIXEL`: pixel word.
- `pixel_last` in 1: the pixel is the final pixel of the frame.
- `pixel_valid` in 1: producer has a pixel.
- `pixel_ready` out 1: the pixel is accepted on any cycle where valid && ready.
- `dout` out 1: registered serial line to the LED chain.
- `busy` out 1: high when state is not IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch gap.

## Operation
- States: IDLE, SHIFT, LATCH.
  - IDLE: `dout`=0. Accept moves to SHIFT with bit=0 and slot=0, and loads the shift register and the last flag.
  - SHIFT: on each `tick`, `dout` <= (slot < (cur_bit ? `T1H_SLOTS` : `T0H_SLOTS`)), then slot increments.
  - At slot `SLOTS_PER_BIT`-1 the block shifts left, sets slot=0 and increments bit.
  - After the final slot of bit `BITS_PER_PIXEL`-1:
    - If a pixel is accepted in the same cycle, the block reloads and stays in SHIFT.
    - Else if the last flag is set, the block goes to LATCH.
    - Else the block goes to IDLE (underrun). `dout` falls low at the next tick-less boundary only, so that slot completes normally.
  - LATCH: `dout`=0. The block counts `RESET_SLOTS` ticks, then pulses `frame_done` and goes to IDLE.
- `pixel_ready` = IDLE, or (SHIFT && bit=`BITS_PER_PIXEL`-1 && slot=`SLOTS_PER_BIT`-1 && `tick`). It is combinational from state and `tick`.
- `pixel_ready` is 0 in LATCH and 0 while `reset` is high.
- Counters are sized $clog2 of their maximum plus one and never wrap past their terminal value.
- `tick` is ignored in IDLE.

## Timing
- Reset values: state IDLE, `dout`=0, `busy`=0, `frame_done`=0, counters 0, shift register 0.
- `dout` updates on the clock edge ending a cycle with `tick`=1. A slot is exactly one tick period.
- First-pixel latency: accept in cycle N. The first high on `dout` follows the first tick at cycle > N.
- Back-to-back pixels produce no gap: slot 0 of the next pixel follows the last slot of the previous one on the next tick.
- `tick` held high permanently gives one slot per clock and is legal.
- `reset` mid-frame: the next edge forces IDLE and `dout`=0. The in-flight pixel is dropped and no `frame_done` is generated.
- `frame_done` is registered and coincides with the `busy` 1→0 transition.

## Configuration
- `WS2812B_TX_UNDERRUN_EN` defined:
  - Adds output `underrun` (1 bit, reset 0). It pulses for one cycle when SHIFT ends a non-last pixel without a new accept.
  - In that case the block enters LATCH instead of IDLE, so the chain latches cleanly and `frame_done` follows.
- Undefined: no `underrun` port, and underrun goes to IDLE as described in Operation.

## Test plan
All scenarios use `SLOTS_PER_BIT`=3, T0H=1, T1H=2, `RESET_SLOTS`=4, with `tick` every 4 cycles.
- Single pixel 0xA00000, last=1:
  - Per-tick `dout` starts H H L, H L L, H H L, H L L, then 20×(H L L).
  - That is 72 slots, followed by 4 low slots.
  - `frame_done` pulses once and `busy` drops in the same cycle.
- Two pixels 0xFFFFFF, 0x000000 with valid held:
  - `pixel_ready` pulses on exactly one cycle, the tick at bit 23 slot 2.
  - Pixel 2 slot 0 is on the very next tick, with 144 contiguous slots and no idle slot.
- Underrun: pixel 0x000001 last=0 with no follow-up.
  - Macro off: IDLE after 72 slots, `frame_done`=0.
  - Macro on: `underrun` pulses once, 4 latch slots follow, then `frame_done`.
- `reset` asserted during bit 10 of a pixel: next edge gives `dout`=0 and `busy`=0. `pixel_ready` stays 0 during reset and is 1 the cycle after release.
- `tick` tied high with 0x800000 last=1: `dout` H H L H L L … for exactly 72 cycles, then 4 low cycles, then `frame_done`.
- `pixel_valid` asserted during LATCH: `pixel_ready` stays 0 until `frame_done`. The pixel is accepted the cycle after.

Source files
------------

// File: rtl/ws2812b_tx.sv
// ws2812b_tx: WS2812B single-wire serializer driven by an external slot tick.
// Pixels arrive on a valid/ready handshake and are sent MSB first; each bit
// spans SLOTS_PER_BIT ticks with a T0H/T1H high pulse. After the last pixel
// the line is held low for RESET_SLOTS ticks and frame_done pulses.
// Optional feature macro: WS2812B_TX_UNDERRUN_EN (adds the underrun pulse and
// latches the chain on an underrun instead of dropping straight to idle).
module ws2812b_tx #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned SLOTS_PER_BIT  = 3,
  parameter int unsigned T0H_SLOTS      = 1,
  parameter int unsigned T1H_SLOTS      = 2,
  parameter int unsigned RESET_SLOTS    = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_last,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      frame_done
`ifdef WS2812B_TX_UNDERRUN_EN
  ,
  output logic                      underrun
`endif
);

  localparam int unsigned BIT_W  = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int unsigned SLOT_W = (SLOTS_PER_BIT > 1) ? $clog2(SLOTS_PER_BIT) : 1;
  localparam int unsigned LCNT_W = (RESET_SLOTS > 1) ? $clog2(RESET_SLOTS) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_BIT - 1);
  localparam logic [SLOT_W-1:0] T0H_L     = SLOT_W'(T0H_SLOTS);
  localparam logic [SLOT_W-1:0] T1H_L     = SLOT_W'(T1H_SLOTS);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(RESET_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [LCNT_W-1:0]         lcnt_q, lcnt_d;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
  logic                      last_q, last_d;
  logic                      dout_d;
  logic                      busy_d;
  logic                      frame_done_d;
`ifdef WS2812B_TX_UNDERRUN_EN
  logic                      underrun_d;
`endif

  logic                      end_of_pixel_c;
  logic                      accept_c;
  logic [SLOT_W-1:0]         high_slots_c;

  // Final tick of the final bit: the only point a follow-up pixel can be taken mid-frame
  assign end_of_pixel_c = (state_q == ST_SHIFT) && tick &&
                          (bit_q == BIT_LAST) && (slot_q == SLOT_LAST);

  // Ready is combinational from state and tick, and held off while in reset
  assign pixel_ready = !reset && ((state_q == ST_IDLE) || end_of_pixel_c);
  assign accept_c    = pixel_valid && pixel_ready;

  // High-pulse width for the bit currently at the MSB of the shift register
  assign high_slots_c = shreg_q[BITS_PER_PIXEL-1] ? T1H_L : T0H_L;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    slot_d       = slot_q;
    lcnt_d       = lcnt_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    dout_d       = dout;
    frame_done_d = 1'b0;
`ifdef WS2812B_TX_UNDERRUN_EN
    underrun_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        if (accept_c) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
          slot_d  = '0;
          lcnt_d  = '0;
          shreg_d = pixel_data;
          last_d  = pixel_last;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          dout_d = (slot_q < high_slots_c);
          if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            shreg_d = shreg_q << 1;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (accept_c) begin
                shreg_d = pixel_data;
                last_d  = pixel_last;
              end else if (last_q) begin
                state_d = ST_LATCH;
                lcnt_d  = '0;
              end else begin
`ifdef WS2812B_TX_UNDERRUN_EN
                underrun_d = 1'b1;
                state_d    = ST_LATCH;
                lcnt_d     = '0;
`else
                state_d = ST_IDLE;
`endif
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end

      ST_LATCH: begin
        dout_d = 1'b0;
        if (tick) begin
          if (lcnt_q == LCNT_LAST) begin
            lcnt_d       = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        dout_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      slot_q     <= '0;
      lcnt_q     <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef WS2812B_TX_UNDERRUN_EN
      underrun   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      slot_q     <= slot_d;
      lcnt_q     <= lcnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      dout       <= dout_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef WS2812B_TX_UNDERRUN_EN
      underrun   <= underrun_d;
`endif
    end
  end

endmodule

// File: tb/tb_ws2812b_tx.sv
// tb_ws2812b_tx: randomized self-checking bench for ws2812b_tx.
// The expected line waveform is built per slot from pixel values and the
// T0H/T1H rules; observed dout is captured after every tick while busy.
module tb_ws2812b_tx;

  localparam int unsigned BPP = 24;
  localparam int unsigned SPB = 3;
  localparam int unsigned T0H = 1;
  localparam int unsigned T1H = 2;
  localparam int unsigned RSL = 4;
`ifdef WS2812B_TX_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           tick;
  logic [BPP-1:0] pixel_data;
  logic           pixel_last;
  logic           pixel_valid;
  logic           pixel_ready;
  logic           dout;
  logic           busy;
  logic           frame_done;
  logic           underrun;

  ws2812b_tx #(
    .BITS_PER_PIXEL(BPP),
    .SLOTS_PER_BIT (SPB),
    .T0H_SLOTS     (T0H),
    .T1H_SLOTS     (T1H),
    .RESET_SLOTS   (RSL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pixel_data (pixel_data),
    .pixel_last (pixel_last),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef WS2812B_TX_UNDERRUN_EN
    ,
    .underrun   (underrun)
`endif
  );

`ifndef WS2812B_TX_UNDERRUN_EN
  assign underrun = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle driver state
  bit tick_all = 1'b0;
  int phase    = 0;
  int cyc      = 0;
  bit s_tick, s_rdy, s_acc, s_busy_pre;

  // One clock cycle: drive tick, sample combinational ready, then cross the edge
  task automatic step();
    tick  = tick_all || (phase == 3);
    phase = (phase + 1) % 4;
    #1;
    s_tick     = tick;
    s_rdy      = pixel_ready;
    s_acc      = pixel_valid && pixel_ready;
    s_busy_pre = busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pixel feed, observation and expectation storage
  logic [BPP-1:0] fd_q[$];
  bit             fl_q[$];
  int             hold_n = 0;
  int             n_acc;
  logic           obs[$];
  bit             exp_q[$];
  int             acc_cyc[$];
  int             fdn_cyc[$];
  int             rdy_hs, rdy_notick, gap, ur_cnt, fd_bad;

  // Reference waveform of one pixel: MSB first, high while slot < pulse width
  task automatic add_pixel_exp(input logic [BPP-1:0] p);
    for (int b = BPP - 1; b >= 0; b--)
      for (int s = 0; s < SPB; s++)
        exp_q.push_back(s < (p[b] ? T1H : T0H));
  endtask

  task automatic add_latch_exp();
    repeat (RSL) exp_q.push_back(1'b0);
  endtask

  // Feed queued pixels with valid held (optionally gated) and record behaviour
  task automatic run_feed(input string tag, input int max_cyc);
    bit started = 1'b0;
    bit ended   = 1'b0;
    int tail    = 0;
    obs.delete(); acc_cyc.delete(); fdn_cyc.delete();
    rdy_hs = 0; rdy_notick = 0; gap = 0; ur_cnt = 0; fd_bad = 0; n_acc = 0;
    for (int c = 0; c < max_cyc && tail < 24; c++) begin
      if (fd_q.size() > 0 && (n_acc == 0 || obs.size() >= hold_n)) begin
        pixel_valid = 1'b1;
        pixel_data  = fd_q[0];
        pixel_last  = fl_q[0];
      end else begin
        pixel_valid = 1'b0;
        pixel_data  = BPP'($urandom);
        pixel_last  = 1'($urandom);
      end
      step();
      if (s_acc) begin
        void'(fd_q.pop_front());
        void'(fl_q.pop_front());
        n_acc++;
        acc_cyc.push_back(cyc);
      end
      if (s_tick && s_busy_pre) obs.push_back(dout);
      if (s_tick && !s_busy_pre && started && !ended) gap++;
      if (s_rdy && s_busy_pre) begin
        if (pixel_valid) rdy_hs++;
        if (!s_tick) rdy_notick++;
      end
      if (frame_done === 1'b1) begin
        fdn_cyc.push_back(cyc);
        if (!(s_busy_pre && busy === 1'b0)) fd_bad++;
      end
      if (underrun === 1'b1) ur_cnt++;
      if (busy === 1'b1) started = 1'b1;
      if (started && busy === 1'b0 && fd_q.size() == 0) ended = 1'b1;
      if (ended) tail++;
    end
    pixel_valid = 1'b0;
    check({tag, ":finished"}, 32'(ended), 32'd1);
  endtask

  // Compare captured slots and pulse counts against the reference
  task automatic compare(input string tag, input int exp_fd, input int exp_ur);
    int mism = 0;
    int n;
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs[i] !== exp_q[i]) mism++;
    check({tag, ":slots"}, 32'(obs.size()), 32'(exp_q.size()));
    check({tag, ":slot_mism"}, 32'(mism), 32'd0);
    check({tag, ":frame_done_cnt"}, 32'(fdn_cyc.size()), 32'(exp_fd));
    check({tag, ":frame_done_busy"}, 32'(fd_bad), 32'd0);
    check({tag, ":underrun_cnt"}, 32'(ur_cnt), 32'(exp_ur));
    check({tag, ":ready_off_tick"}, 32'(rdy_notick), 32'd0);
  endtask

  initial begin
    int seen;
    int fd_seen;
    int np;
    logic [BPP-1:0] p;
    bit l;

    reset       = 1'b1;
    tick        = 1'b0;
    pixel_valid = 1'b1;
    pixel_data  = 24'hFFFFFF;
    pixel_last  = 1'b1;

    // Reset state, with a pixel offered that must not be taken
    step();
    check("rst:ready", 32'(s_rdy), 32'd0);
    step();
    check("rst:ready2", 32'(s_rdy), 32'd0);
    check("rst:dout", 32'(dout), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:frame_done", 32'(frame_done), 32'd0);
    reset       = 1'b0;
    pixel_valid = 1'b0;
    step();
    check("rst:busy_after", 32'(busy), 32'd0);

    // Single pixel, last
    exp_q.delete();
    fd_q.push_back(24'hA00000); fl_q.push_back(1'b1);
    add_pixel_exp(24'hA00000); add_latch_exp();
    run_feed("single", 2000);
    compare("single", 1, 0);
    check("single:ready_hs", 32'(rdy_hs), 32'd0);

    // Two pixels back to back
    exp_q.delete();
    fd_q.push_back(24'hFFFFFF); fl_q.push_back(1'b0);
    fd_q.push_back(24'h000000); fl_q.push_back(1'b1);
    add_pixel_exp(24'hFFFFFF); add_pixel_exp(24'h000000); add_latch_exp();
    run_feed("b2b", 3000);
    compare("b2b", 1, 0);
    check("b2b:ready_hs", 32'(rdy_hs), 32'd1);
    check("b2b:gap", 32'(gap), 32'd0);

    // Underrun: non-last pixel with nothing following
    exp_q.delete();
    fd_q.push_back(24'h000001); fl_q.push_back(1'b0);
    add_pixel_exp(24'h000001);
    if (UR_EN) add_latch_exp();
    run_feed("underrun", 2000);
    compare("underrun", UR_EN ? 1 : 0, UR_EN ? 1 : 0);

    // Valid during the latch gap is held off until frame_done
    exp_q.delete();
    hold_n = 72;
    fd_q.push_back(24'h123456); fl_q.push_back(1'b1);
    fd_q.push_back(24'h654321); fl_q.push_back(1'b1);
    add_pixel_exp(24'h123456); add_latch_exp();
    add_pixel_exp(24'h654321); add_latch_exp();
    run_feed("latchwait", 3000);
    hold_n = 0;
    compare("latchwait", 2, 0);
    check("latchwait:ready_hs", 32'(rdy_hs), 32'd0);
    if (acc_cyc.size() >= 2 && fdn_cyc.size() >= 1)
      check("latchwait:accept_cyc", 32'(acc_cyc[1]), 32'(fdn_cyc[0] + 1));
    else
      check("latchwait:accepts", 32'(acc_cyc.size()), 32'd2);

    // Tick tied high: one slot per clock
    exp_q.delete();
    tick_all = 1'b1;
    fd_q.push_back(24'h800000); fl_q.push_back(1'b1);
    add_pixel_exp(24'h800000); add_latch_exp();
    run_feed("tickhigh", 500);
    tick_all = 1'b0;
    compare("tickhigh", 1, 0);
    if (acc_cyc.size() >= 1 && fdn_cyc.size() >= 1)
      check("tickhigh:frame_len", 32'(fdn_cyc[0] - acc_cyc[0]), 32'(BPP * SPB + RSL));
    else
      check("tickhigh:events", 32'(fdn_cyc.size()), 32'd1);

    // Reset while bit 10 is on the wire
    seen = 0;
    pixel_valid = 1'b1; pixel_data = 24'hC3A5F0; pixel_last = 1'b1;
    for (int c = 0; c < 1000 && seen < 31; c++) begin
      step();
      if (s_acc) pixel_valid = 1'b0;
      if (s_tick && s_busy_pre) seen++;
    end
    check("midrst:reached", 32'(seen), 32'd31);
    reset = 1'b1;
    step();
    check("midrst:ready", 32'(s_rdy), 32'd0);
    check("midrst:dout", 32'(dout), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    step();
    check("midrst:ready2", 32'(s_rdy), 32'd0);
    reset = 1'b0;
    step();
    check("midrst:ready_rel", 32'(s_rdy), 32'd1);
    fd_seen = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (frame_done === 1'b1 || busy !== 1'b0) fd_seen++;
    end
    check("midrst:quiet", 32'(fd_seen), 32'd0);

    // Randomized streams with valid held; mid-stream last flags are overridden by the next accept
    for (int it = 0; it < 8; it++) begin
      exp_q.delete();
      np = int'($urandom_range(1, 3));
      tick_all = ($urandom_range(0, 3) == 0);
      l = 1'b0;
      for (int i = 0; i < np; i++) begin
        p = BPP'($urandom);
        l = 1'($urandom);
        fd_q.push_back(p); fl_q.push_back(l);
        add_pixel_exp(p);
      end
      if (l || UR_EN) add_latch_exp();
      run_feed($sformatf("rand%0d", it), 4000);
      compare($sformatf("rand%0d", it), (l || UR_EN) ? 1 : 0, (UR_EN && !l) ? 1 : 0);
      check($sformatf("rand%0d:ready_hs", it), 32'(rdy_hs), 32'(np - 1));
      check($sformatf("rand%0d:gap", it), 32'(gap), 32'd0);
      fd_q.delete(); fl_q.delete();
    end
    tick_all = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
